// File: rtl/dl_skid_buf.sv
// ---------------------------------------------------------------------------
// dl_skid_buf
//
// Two-entry valid/ready skid buffer. A main register drives out_data. A skid
// register catches one extra payload that arrives while the downstream is
// stalled. The handshake outputs come straight from flops, so there is no
// combinational path from out_rdy to in_rdy.
//
// Optional feature (compile-time macro):
//   DL_SKID_BUF_XFER_CNT_EN  defined   -> 16-bit wrapping count of output
//                                         transfers on xfer_cnt
//                            undefined -> counter removed, xfer_cnt tied to 0
//
// Parameters:
//   NUM_BITS  payload width in bits
//
// Ports:
//   clk       single clock, rising edge
//   rst_n     asynchronous, active-low reset
//   in_val    upstream payload valid
//   in_rdy    buffer can accept a payload this cycle
//   in_data   upstream payload
//   out_val   out_data holds a valid payload
//   out_rdy   downstream accepts the payload
//   out_data  registered payload (main register)
//   xfer_cnt  count of completed output transfers
// ---------------------------------------------------------------------------
module dl_skid_buf #(
  parameter int NUM_BITS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_val,
  output logic                in_rdy,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                out_val,
  input  logic                out_rdy,
  output logic [NUM_BITS-1:0] out_data,
  output logic [15:0]         xfer_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              r_state;
  logic [NUM_BITS-1:0] r_main;
  logic [NUM_BITS-1:0] r_skid;
  logic                r_out_val;
  logic                r_in_rdy;

  // The handshake flags are registered copies of the state decode:
  //   out_val = (state != EMPTY), in_rdy = (state != FULL).
  // Each branch that moves the state also updates both flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= EMPTY;
      r_main    <= '0;
      r_skid    <= '0;
      r_out_val <= 1'b0;
      r_in_rdy  <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (in_val) begin
            r_main    <= in_data;
            r_state   <= BUSY;
            r_out_val <= 1'b1;
            r_in_rdy  <= 1'b1;
          end
        end
        BUSY: begin
          if (in_val && out_rdy) begin
            // The main register is consumed and refilled in the same cycle.
            r_main <= in_data;
          end else if (in_val) begin
            // Downstream is stalled: park the new payload in the skid register.
            r_skid    <= in_data;
            r_state   <= FULL;
            r_out_val <= 1'b1;
            r_in_rdy  <= 1'b0;
          end else if (out_rdy) begin
            r_state   <= EMPTY;
            r_out_val <= 1'b0;
            r_in_rdy  <= 1'b1;
          end
        end
        FULL: begin
          // in_rdy is low here, so in_data is ignored.
          if (out_rdy) begin
            r_main    <= r_skid;
            r_state   <= BUSY;
            r_out_val <= 1'b1;
            r_in_rdy  <= 1'b1;
          end
        end
        default: begin
          r_state   <= EMPTY;
          r_out_val <= 1'b0;
          r_in_rdy  <= 1'b1;
        end
      endcase
    end
  end

  assign out_val  = r_out_val;
  assign in_rdy   = r_in_rdy;
  assign out_data = r_main;

`ifdef DL_SKID_BUF_XFER_CNT_EN
  logic        w_out_xfer;
  logic [15:0] r_xfer_cnt;

  assign w_out_xfer = r_out_val & out_rdy;

  // Wraps naturally from 0xFFFF to 0x0000.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= 16'h0000;
    end else if (w_out_xfer) begin
      r_xfer_cnt <= r_xfer_cnt + 16'h0001;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`else
  assign xfer_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dl_skid_buf.sv
module tb_dl_skid_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_val;
  logic        in_rdy;
  logic [7:0]  in_data;
  logic        out_val;
  logic        out_rdy;
  logic [7:0]  out_data;
  logic [15:0] xfer_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: the buffer is a FIFO of capacity 2 holding payloads in order.
  logic [7:0] q[$];
  int unsigned model_cnt = 0;

  always #5 clk = ~clk;

  dl_skid_buf #(.NUM_BITS(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_data  (in_data),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .xfer_cnt (xfer_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_cnt();
`ifdef DL_SKID_BUF_XFER_CNT_EN
    return model_cnt[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check_outputs();
    chk("out_val", out_val, (q.size() != 0));
    chk("in_rdy", in_rdy, (q.size() != 2));
    if (q.size() != 0) chk("out_data", out_data, q[0]);
    chk("xfer_cnt", xfer_cnt, exp_cnt());
  endtask

  // Called just after a falling edge: check, drive, advance one cycle.
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    logic in_x, out_x;
    check_outputs();
    in_val  = v;
    in_data = d;
    // Drive the opposite out_rdy first: in_rdy must not react to it.
    out_rdy = !r;
    #1;
    chk("in_rdy_indep", in_rdy, (q.size() != 2));
    out_rdy = r;
    in_x  = v && (q.size() < 2);
    out_x = r && (q.size() > 0);
    @(posedge clk);
    if (out_x) begin
      void'(q.pop_front());
      model_cnt++;
    end
    if (in_x) q.push_back(d);
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b0;
    in_val  = 1'b0;
    in_data = 8'h00;
    out_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_val", out_val, 1'b0);
    chk("rst_in_rdy", in_rdy, 1'b1);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_xfer_cnt", xfer_cnt, 16'h0000);
    rst_n = 1'b1;

    // Streaming 0x01..0x10 with out_rdy held high.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    // Skid: fill both entries while stalled, then drain.
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    chk("skid_full_in_rdy", in_rdy, 1'b0);
    chk("skid_hold_data", out_data, 8'hA5);
    step(1'b1, 8'hFF, 1'b0);  // ignored while full
    chk("skid_still_a5", out_data, 8'hA5);
    step(1'b0, 8'h00, 1'b1);
    chk("skid_second", out_data, 8'h3C);
    step(1'b0, 8'h00, 1'b1);
    chk("skid_drained", out_val, 1'b0);

    // Random stall pattern against the model.
    for (int i = 0; i < 10000; i++)
      step(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0));

    // Reset mid-FULL, asserted between edges.
    while (q.size() < 2) step(1'b1, 8'($urandom), 1'b0);
    check_outputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_val", out_val, 1'b0);
    chk("midrst_in_rdy", in_rdy, 1'b1);
    chk("midrst_out_data", out_data, 8'h00);
    chk("midrst_xfer_cnt", xfer_cnt, 16'h0000);
    q.delete();
    model_cnt = 0;
    in_val = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // First input transfer on the first edge after release.
    step(1'b1, 8'h5A, 1'b0);
    chk("post_rst_first", out_data, 8'h5A);
    step(1'b0, 8'h00, 1'b1);

`ifdef DL_SKID_BUF_XFER_CNT_EN
    while (model_cnt < 65535) step(1'b1, 8'($urandom), 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("cnt_ffff", xfer_cnt, 16'hFFFF);
    step(1'b0, 8'h00, 1'b1);
    chk("cnt_0000", xfer_cnt, 16'h0000);
    step(1'b1, 8'h11, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("cnt_0001", xfer_cnt, 16'h0001);
`else
    for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b1);
    chk("cnt_tied_zero", xfer_cnt, 16'h0000);
`endif
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dl_skid_buf.md
DL_SKID_BUF -- requirements
Module: dl_skid_buf

Interface
REQ-001 SHALL have parameter NUM_BITS, default 1, giving the payload width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_val  input  1  upstream payload valid.
REQ-005 SHALL have port in_rdy  output  1  block can accept a payload this cycle.
REQ-006 SHALL have port in_data  input  NUM_BITS  upstream payload.
REQ-007 SHALL have port out_val  output  1  out_data holds a valid payload.
REQ-008 SHALL have port out_rdy  input  1  downstream (bitwise logic unit operand path) accepts.
REQ-009 SHALL have port out_data  output  NUM_BITS  registered payload to downstream.
REQ-010 SHALL have port xfer_cnt  output  16  count of completed output transfers.

Function
REQ-011 SHALL be a 2-entry valid/ready skid buffer: one main register driving out_data, plus one skid register.
REQ-012 SHALL define an input transfer as in_val & in_rdy, and an output transfer as out_val & out_rdy, each in the same cycle.
REQ-013 SHALL implement states EMPTY (no entries), BUSY (main only), and FULL (main and skid).
REQ-014 SHALL derive outputs from state only: out_val = (state != EMPTY), in_rdy = (state != FULL), out_data = main register; there SHALL be no combinational path from out_rdy to in_rdy.
REQ-015 EMPTY: in_val SHALL load in_data into main and go to BUSY; otherwise stay EMPTY.
REQ-016 BUSY transitions SHALL be:
- in_val & out_rdy -> load main, stay BUSY.
- in_val & !out_rdy -> load skid, go to FULL.
- !in_val & out_rdy -> go to EMPTY.
- otherwise hold.
REQ-017 FULL: out_rdy SHALL move skid to main and go to BUSY; otherwise hold; in_data SHALL be ignored.
REQ-018 Latency SHALL be 1 cycle from input transfer to out_val when EMPTY; throughput SHALL be 1 transfer per cycle when out_rdy is held high.
REQ-019 Payload order SHALL be preserved; no payload SHALL be dropped or duplicated under any in_val/out_rdy pattern.
REQ-020 out_data and out_val SHALL remain stable while out_val=1 and out_rdy=0.
REQ-021 Register contents SHALL not change in cycles with no transfer.

Reset
REQ-022 While rst_n=0 the block SHALL hold the following values:
- state = EMPTY, so out_val = 0 and in_rdy = 1.
- main and skid registers = 0.
- xfer_cnt = 0.
REQ-023 Reset asserted mid-operation SHALL immediately discard all held payloads, with no output transfer counted in that cycle.
REQ-024 The first input transfer SHALL be possible on the first rising edge with rst_n=1.

Configuration
REQ-025 Macro DL_SKID_BUF_XFER_CNT_EN defined SHALL compile in a 16-bit counter that increments on each output transfer and wraps 0xFFFF -> 0x0000.
REQ-026 Macro DL_SKID_BUF_XFER_CNT_EN undefined SHALL compile out the counter logic, with xfer_cnt tied to 0; all other behaviour SHALL be identical.

Verification
REQ-027 Streaming: NUM_BITS=8, reset, then in_val=1 with data 0x01..0x10 on consecutive cycles and out_rdy=1 -> out_data is 0x01..0x10 on consecutive cycles, 1 cycle delayed; in_rdy stays 1.
REQ-028 Skid: send 0xA5 then 0x3C with out_rdy=0 -> state FULL, in_rdy=0, out_data=0xA5 held; raise out_rdy -> 0xA5 then 0x3C delivered, then out_val=0.
REQ-029 Random stall: random in_val/out_rdy for 10,000 cycles against a scoreboard -> order preserved, no loss or duplication, in_rdy never depends on out_rdy in the same cycle.
REQ-030 Reset mid-FULL: with the buffer FULL, pulse rst_n=0 asynchronously between edges -> out_val=0, in_rdy=1, and out_data=0 immediately, before the next clock edge.
REQ-031 Counter (macro defined): preload via 65,535 transfers, then 2 more -> xfer_cnt reads 0xFFFF, then 0x0000, then 0x0001; macro undefined -> xfer_cnt=0 throughout.
